// File: rtl/fetch_queue_unit.sv
// Fetch stage with an integrated DEPTH-entry prefetch queue between the
// combinational instruction memory and decode.
module fetch_queue_unit #(
   parameter int                ADDR_W   = 6,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fetch_en,
   output logic [ADDR_W-1:0]        imem_addr,
   input  logic [DATA_W-1:0]        imem_data,
   input  logic                     redirect_valid,
   input  logic [ADDR_W-1:0]        redirect_pc,
   input  logic                     deq_ready,
   output logic                     deq_valid,
   output logic [DATA_W-1:0]        deq_inst,
   output logic [ADDR_W-1:0]        deq_pc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

   logic [ADDR_W-1:0] fetch_pc;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [ADDR_W-1:0] mem_pc   [DEPTH];
   logic [DATA_W-1:0] mem_inst [DEPTH];

   logic full;
   logic deq_fire;
   logic enq_fire;

   // Handshake: an entry transfers to decode on every rising edge where
   // deq_valid and deq_ready are both high; deq_valid depends only on
   // registered state, so decode may derive deq_ready from deq_* freely.
   assign deq_valid = (count != '0);
   assign deq_fire  = deq_valid & deq_ready;
   assign full      = (count == CNT_FULL);
   assign enq_fire  = fetch_en & ~redirect_valid & (~full | deq_fire);

   assign imem_addr = fetch_pc;
   assign deq_inst  = deq_valid ? mem_inst[rd_ptr] : '0;
   assign deq_pc    = deq_valid ? mem_pc[rd_ptr]   : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         if (enq_fire) begin
            wr_ptr   <= wr_ptr + PTR_ONE;
            fetch_pc <= fetch_pc + PC_ONE;
         end
         if (deq_fire) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({enq_fire, deq_fire})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked entirely by count.
   always_ff @(posedge clk) begin
      if (enq_fire) begin
         mem_pc[wr_ptr]   <= fetch_pc;
         mem_inst[wr_ptr] <= imem_data;
      end
   end

endmodule
